// File: rtl/pll_lock_supervisor_if.sv
// PLL-side signal bundle for the lock supervisor: lock in, PLL reset and
// qualified system reset / status out. master = supervisor, slave = PLL + consumers.
interface pll_lock_supervisor_if;
  logic       pll_lock;
  logic       pll_resetb;
  logic       sys_reset;
  logic       locked;
  logic       fail;
  logic [7:0] lock_loss_count;

  modport master (
    input  pll_lock,
    output pll_resetb, sys_reset, locked, fail, lock_loss_count
  );

  modport slave (
    output pll_lock,
    input  pll_resetb, sys_reset, locked, fail, lock_loss_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor in the reference-clock domain: holds the PLL in reset, waits for
// lock with timeout and retries, qualifies lock stability, then releases sys_reset; all outputs registered.
module pll_lock_supervisor #(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 16000,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_ATTEMPTS        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pll_lock_supervisor_if.master bus
);

  localparam int MAX_AB = (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RESET_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);
  localparam int AW     = $clog2(MAX_ATTEMPTS + 1);

  typedef enum logic [2:0] {
    S_HOLD, S_WAIT_LOCK, S_QUALIFY, S_RUN, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   attempts_q, attempts_d;
  logic [7:0]      loss_cnt_q, loss_cnt_d;
  logic            sync1_q, lock_s_q;
  logic            pll_resetb_q, sys_reset_q, locked_q, fail_q;
  logic            attempt_fail;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    attempts_d   = attempts_q;
    loss_cnt_d   = loss_cnt_q;
    attempt_fail = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (cnt_q == CW'(RESET_HOLD_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lock_s_q) begin
          if (LOCK_STABLE_CYCLES == 1) begin
            state_d = S_RUN;
          end else begin
            state_d = S_QUALIFY;
            cnt_d   = CW'(1);
          end
        end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_QUALIFY: begin
        if (!lock_s_q) begin
          attempt_fail = 1'b1;
        end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
        end
      end
      S_FAIL: ;
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    if (attempt_fail) begin
      attempts_d = attempts_q + AW'(1);
      cnt_d      = '0;
      state_d    = (attempts_d == AW'(MAX_ATTEMPTS)) ? S_FAIL : S_HOLD;
    end

    if (state_d == S_RUN && state_q != S_RUN) begin
      attempts_d = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      attempts_q   <= '0;
      loss_cnt_q   <= '0;
      sync1_q      <= 1'b0;
      lock_s_q     <= 1'b0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      attempts_q   <= attempts_d;
      loss_cnt_q   <= loss_cnt_d;
      sync1_q      <= bus.pll_lock;
      lock_s_q     <= sync1_q;
      // Outputs decoded from the next state so they change on the same edge as the state.
      pll_resetb_q <= (state_d == S_WAIT_LOCK) || (state_d == S_QUALIFY) || (state_d == S_RUN);
      sys_reset_q  <= (state_d != S_RUN);
      locked_q     <= (state_d == S_RUN);
      fail_q       <= (state_d == S_FAIL);
    end
  end

  assign bus.pll_resetb      = pll_resetb_q;
  assign bus.sys_reset       = sys_reset_q;
  assign bus.locked          = locked_q;
  assign bus.fail            = fail_q;
  assign bus.lock_loss_count = loss_cnt_q;

endmodule
